keypad_scan_ctrl: RTL

// - Sequences the 4x4 matrix keypad: drives column scan, debounces presses/releases, decodes key.
// - Keeps a two-digit history (newest/previous) that feeds the dual seven-segment display driver.
// - Sits between the keypad pins and the display logic in top, clocked by the 6 MHz HSOSC.

---
 rtl/keypad_scan_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scan_ctrl : 4x4 keypad scan, debounce, decode, 2-digit history    |
// | Option: define KEYPAD_AUTOREPEAT_EN for hold-to-repeat. Revision: 1.0    |
// +--------------------------------------------------------------------------+
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 6000,
  parameter int DEBOUNCE_CYCLES = 120000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 3000000
`endif
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic [3:0] Digit0,
  output logic [3:0] Digit1
);

  localparam int c_cnt_max = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one = 1;
  localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic [1:0]         r_col, w_col_n;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_n;
  logic [3:0]         r_pat, w_pat_n;
  logic [3:0]         r_sync1, r_rs;
  logic               w_commit;
  logic               w_one_low;
  logic [3:0]         w_inv;
  logic [1:0]         w_row;
  logic [3:0]         w_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int c_rpt_w = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [c_rpt_w-1:0] c_rpt_one  = 1;
  localparam logic [c_rpt_w-1:0] c_rpt_last = c_rpt_w'(REPEAT_CYCLES - 1);
  logic [c_rpt_w-1:0] r_rpt, w_rpt_n;
`endif

  assign Cols      = ~(4'b0001 << r_col);
  assign w_inv     = ~r_rs;
  assign w_one_low = (w_inv != 4'd0) && ((w_inv & (w_inv - 4'd1)) == 4'd0);

  // Row index of the single low bit in the latched pattern
  always_comb begin
    w_row = 2'd0;
    case (r_pat)
      4'b1101: w_row = 2'd1;
      4'b1011: w_row = 2'd2;
      4'b0111: w_row = 2'd3;
      default: w_row = 2'd0;
    endcase
  end

  always_comb begin
    w_code = 4'h0;
    case ({w_row, r_col})
      4'd0:    w_code = 4'h1;
      4'd1:    w_code = 4'h2;
      4'd2:    w_code = 4'h3;
      4'd3:    w_code = 4'hA;
      4'd4:    w_code = 4'h4;
      4'd5:    w_code = 4'h5;
      4'd6:    w_code = 4'h6;
      4'd7:    w_code = 4'hB;
      4'd8:    w_code = 4'h7;
      4'd9:    w_code = 4'h8;
      4'd10:   w_code = 4'h9;
      4'd11:   w_code = 4'hC;
      4'd12:   w_code = 4'hE;
      4'd13:   w_code = 4'h0;
      4'd14:   w_code = 4'hF;
      default: w_code = 4'hD;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_cnt_n   = r_cnt;
    w_pat_n   = r_pat;
    w_commit  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rpt_n   = r_rpt;
`endif
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == c_scan_last) begin
          w_cnt_n = '0;
          if (w_one_low) begin
            w_pat_n   = r_rs;
            w_state_n = ST_DEBOUNCE;
          end else begin
            w_col_n = r_col + 2'd1;
          end
        end else begin
          w_cnt_n = r_cnt + c_cnt_one;
        end
      end
      ST_DEBOUNCE: begin
        if (r_rs != r_pat) begin
          w_state_n = ST_SCAN;
          w_col_n   = r_col + 2'd1;
          w_cnt_n   = '0;
        end else if (r_cnt == c_deb_last) begin
          w_commit  = 1'b1;
          w_state_n = ST_HELD;
          w_cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          w_rpt_n   = '0;
`endif
        end else begin
          w_cnt_n = r_cnt + c_cnt_one;
        end
      end
      ST_HELD: begin
        // Column stays frozen, so keys in other columns cannot disturb the hold
        if (r_rs == 4'hF) begin
          w_state_n = ST_RELEASE;
          w_cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          w_rpt_n   = '0;
        end else if (r_rpt == c_rpt_last) begin
          w_commit = 1'b1;
          w_rpt_n  = '0;
        end else begin
          w_rpt_n = r_rpt + c_rpt_one;
`endif
        end
      end
      default: begin
        if (r_rs != 4'hF) begin
          w_state_n = ST_HELD;
          w_cnt_n   = '0;
        end else if (r_cnt == c_deb_last) begin
          w_state_n = ST_SCAN;
          w_col_n   = r_col + 2'd1;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + c_cnt_one;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_SCAN;
      r_col    <= 2'd0;
      r_cnt    <= '0;
      r_pat    <= 4'hF;
      r_sync1  <= 4'hF;
      r_rs     <= 4'hF;
      KeyCode  <= 4'h0;
      KeyValid <= 1'b0;
      Digit0   <= 4'h0;
      Digit1   <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rpt    <= '0;
`endif
    end else begin
      r_sync1  <= Rows;
      r_rs     <= r_sync1;
      r_state  <= w_state_n;
      r_col    <= w_col_n;
      r_cnt    <= w_cnt_n;
      r_pat    <= w_pat_n;
      KeyValid <= w_commit;
      if (w_commit) begin
        KeyCode <= w_code;
        Digit0  <= w_code;
        Digit1  <= Digit0;
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rpt    <= w_rpt_n;
`endif
    end
  end

endmodule
`default_nettype wire
